// File: rtl/regfile_write_arbiter.sv
// Shares the register file's single write port between two writeback
// requesters (req0 = ALU, req1 = memory load). Each requester feeds a
// one-entry hold buffer. Arbitration is round-robin, except when both holds
// target the same register: then the older entry wins so that writes to any
// register reach the write port in acceptance order.
//
// Handshake (both requesters): reqN_valid is raised with reqN_addr/reqN_data
// and all three stay stable until a clock edge where reqN_ready is also high;
// that edge is the transfer. reqN_ready is high when the hold is empty or is
// being drained by this cycle's grant, so one transfer per requester per cycle
// is possible. Transfers addressed to XZR are accepted and dropped.
module regfile_write_arbiter #(
  parameter int ADDR_W   = 5,
  parameter int DATA_W   = 64,
  parameter int ZERO_REG = 31
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0_valid,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [DATA_W-1:0] req0_data,
  output logic              req0_ready,
  input  logic              req1_valid,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [DATA_W-1:0] req1_data,
  output logic              req1_ready,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  input  logic [ADDR_W-1:0] chk_addr1,
  input  logic [ADDR_W-1:0] chk_addr2,
  output logic              busy1,
  output logic              busy2,
  output logic [7:0]        conflict_cnt
);

  localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(ZERO_REG);

  logic              hold0_full, hold1_full;
  logic [ADDR_W-1:0] hold0_addr, hold1_addr;
  logic [DATA_W-1:0] hold0_data, hold1_data;
  logic              rr_ptr;     // 0: req0 favoured next time round-robin applies
  logic              older_sel;  // which hold was filled first (valid when both full)

  logic grant0, grant1, rr_grant;
  logic acc0, acc1, keep0, keep1;
  logic remain0, remain1;
  logic both_full;

  assign both_full = hold0_full && hold1_full;

  // Pick one hold per cycle: a lone full hold always wins; two holds on the
  // same register go oldest-first; otherwise the round-robin pointer decides.
  always_comb begin
    grant0   = 1'b0;
    grant1   = 1'b0;
    rr_grant = 1'b0;
    if (both_full) begin
      if (hold0_addr == hold1_addr) begin
        if (older_sel) grant1 = 1'b1;
        else           grant0 = 1'b1;
      end else begin
        rr_grant = 1'b1;
        if (rr_ptr) grant1 = 1'b1;
        else        grant0 = 1'b1;
      end
    end else if (hold0_full) begin
      grant0 = 1'b1;
    end else if (hold1_full) begin
      grant1 = 1'b1;
    end
  end

  assign req0_ready = !hold0_full || grant0;
  assign req1_ready = !hold1_full || grant1;

  assign acc0  = req0_valid && req0_ready;
  assign acc1  = req1_valid && req1_ready;
  assign keep0 = acc0 && (req0_addr != ZERO_ADDR);
  assign keep1 = acc1 && (req1_addr != ZERO_ADDR);

  // A hold that stays occupied across this edge (full and not granted).
  assign remain0 = hold0_full && !grant0;
  assign remain1 = hold1_full && !grant1;

  // Hold buffer 0: load on a kept transfer, otherwise drain on grant.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hold0_full <= 1'b0;
      hold0_addr <= '0;
      hold0_data <= '0;
    end else if (keep0) begin
      hold0_full <= 1'b1;
      hold0_addr <= req0_addr;
      hold0_data <= req0_data;
    end else if (grant0) begin
      hold0_full <= 1'b0;
    end
  end

  // Hold buffer 1: load on a kept transfer, otherwise drain on grant.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hold1_full <= 1'b0;
      hold1_addr <= '0;
      hold1_data <= '0;
    end else if (keep1) begin
      hold1_full <= 1'b1;
      hold1_addr <= req1_addr;
      hold1_data <= req1_data;
    end else if (grant1) begin
      hold1_full <= 1'b0;
    end
  end

  // Age tracking: a hold filling next to an occupied one is the younger;
  // two holds filling together treat the load (req1) as older.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      older_sel <= 1'b0;
    end else if (keep0 && keep1) begin
      older_sel <= 1'b1;
    end else if (keep0 && remain1) begin
      older_sel <= 1'b1;
    end else if (keep1 && remain0) begin
      older_sel <= 1'b0;
    end
  end

  // Round-robin pointer moves past the requester granted under that rule.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rr_ptr <= 1'b0;
    end else if (rr_grant) begin
      rr_ptr <= grant0;
    end
  end

  // Registered write port; address/data keep their last value when idle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_en   <= 1'b0;
      wr_addr <= '0;
      wr_data <= '0;
    end else begin
      wr_en <= grant0 || grant1;
      if (grant0) begin
        wr_addr <= hold0_addr;
        wr_data <= hold0_data;
      end else if (grant1) begin
        wr_addr <= hold1_addr;
        wr_data <= hold1_data;
      end
    end
  end

  // Saturating count of cycles where both holds are occupied.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      conflict_cnt <= 8'd0;
    end else if (both_full && (conflict_cnt != 8'hFF)) begin
      conflict_cnt <= conflict_cnt + 8'd1;
    end
  end

  // A read address is busy if any not-yet-committed write targets it.
  always_comb begin
    busy1 = (chk_addr1 != ZERO_ADDR) &&
            ((hold0_full && (chk_addr1 == hold0_addr)) ||
             (hold1_full && (chk_addr1 == hold1_addr)) ||
             (wr_en      && (chk_addr1 == wr_addr)));
    busy2 = (chk_addr2 != ZERO_ADDR) &&
            ((hold0_full && (chk_addr2 == hold0_addr)) ||
             (hold1_full && (chk_addr2 == hold1_addr)) ||
             (wr_en      && (chk_addr2 == wr_addr)));
  end

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed bench for regfile_write_arbiter. A transaction-level model
// (entries with sequence numbers, a round-robin integer) predicts every
// output each cycle; a per-register expected queue checks write ordering;
// directed literal checks pin the scenarios.
module tb_regfile_write_arbiter;
  localparam int ADDR_W   = 5;
  localparam int DATA_W   = 64;
  localparam int ZERO_REG = 31;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  logic              req0_valid, req1_valid;
  logic [ADDR_W-1:0] req0_addr, req1_addr;
  logic [DATA_W-1:0] req0_data, req1_data;
  logic              req0_ready, req1_ready;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic [ADDR_W-1:0] chk_addr1, chk_addr2;
  logic              busy1, busy2;
  logic [7:0]        conflict_cnt;

  regfile_write_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .ZERO_REG(ZERO_REG)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_addr(req0_addr), .req0_data(req0_data), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_addr(req1_addr), .req1_data(req1_data), .req1_ready(req1_ready),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .chk_addr1(chk_addr1), .chk_addr2(chk_addr2), .busy1(busy1), .busy2(busy2),
    .conflict_cnt(conflict_cnt)
  );

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // ---------------- model ----------------
  bit                m_v   [2];
  logic [ADDR_W-1:0] m_a   [2];
  logic [DATA_W-1:0] m_d   [2];
  int                m_seq [2];
  int                seq_ctr;
  int                m_rr;
  logic              m_wr_en;
  logic [ADDR_W-1:0] m_wr_addr;
  logic [DATA_W-1:0] m_wr_data;
  int                m_cnt;

  logic [ADDR_W+DATA_W-1:0] exp_q[$];
  logic [DATA_W-1:0]        regs [32];

  task automatic model_clear();
    for (int i = 0; i < 2; i++) begin
      m_v[i] = 0; m_a[i] = '0; m_d[i] = '0; m_seq[i] = 0;
    end
    seq_ctr = 0; m_rr = 0; m_cnt = 0;
    m_wr_en = 0; m_wr_addr = '0; m_wr_data = '0;
    exp_q.delete();
  endtask

  // Which entry the write port takes this cycle (-1 = none).
  function automatic int m_grant();
    if (m_v[0] && m_v[1]) begin
      if (m_a[0] == m_a[1]) return (m_seq[1] < m_seq[0]) ? 1 : 0;
      return m_rr;
    end
    if (m_v[0]) return 0;
    if (m_v[1]) return 1;
    return -1;
  endfunction

  function automatic logic exp_busy(input logic [ADDR_W-1:0] a);
    if (a == ZERO_REG) return 1'b0;
    return (m_v[0] && a == m_a[0]) || (m_v[1] && a == m_a[1]) || (m_wr_en && a == m_wr_addr);
  endfunction

  task automatic model_step();
    int g;
    bit both, a0, a1;
    g    = m_grant();
    both = m_v[0] && m_v[1];
    a0   = req0_valid && (!m_v[0] || g == 0);
    a1   = req1_valid && (!m_v[1] || g == 1);
    if (both && m_cnt < 255) m_cnt++;
    if (g >= 0) begin
      m_wr_en = 1; m_wr_addr = m_a[g]; m_wr_data = m_d[g];
      m_v[g] = 0;
      if (both && m_a[0] != m_a[1]) m_rr = 1 - g;
    end else begin
      m_wr_en = 0;
    end
    // The load side is taken first so it is older on a same-edge tie.
    if (a1 && req1_addr != ZERO_REG) begin
      m_v[1] = 1; m_a[1] = req1_addr; m_d[1] = req1_data; m_seq[1] = seq_ctr++;
      exp_q.push_back({req1_addr, req1_data});
    end
    if (a0 && req0_addr != ZERO_REG) begin
      m_v[0] = 1; m_a[0] = req0_addr; m_d[0] = req0_data; m_seq[0] = seq_ctr++;
      exp_q.push_back({req0_addr, req0_data});
    end
  endtask

  initial begin : model_proc
    model_clear();
    forever begin
      @(posedge clk or negedge reset);
      if (!reset) model_clear();
      else        model_step();
    end
  end

  // ---------------- compare + scoreboard ----------------
  bit bp_phase  = 0;
  bit saw_low0  = 0;
  int w10_cnt   = 0;

  initial begin : cmp_proc
    int g;
    int idx;
    forever begin
      @(negedge clk);
      g = m_grant();
      check("cmp_wr_en",        wr_en,        m_wr_en);
      check("cmp_wr_addr",      wr_addr,      m_wr_addr);
      check("cmp_wr_data",      wr_data,      m_wr_data);
      check("cmp_req0_ready",   req0_ready,   !m_v[0] || g == 0);
      check("cmp_req1_ready",   req1_ready,   !m_v[1] || g == 1);
      check("cmp_busy1",        busy1,        exp_busy(chk_addr1));
      check("cmp_busy2",        busy2,        exp_busy(chk_addr2));
      check("cmp_conflict_cnt", conflict_cnt, m_cnt);
      if (bp_phase && !req0_ready) saw_low0 = 1;
      if (reset && wr_en) begin
        idx = -1;
        for (int i = 0; i < exp_q.size(); i++) begin
          if (exp_q[i][ADDR_W+DATA_W-1:DATA_W] == wr_addr) begin
            idx = i;
            break;
          end
        end
        check("sb_write_expected", idx >= 0, 1);
        if (idx >= 0) begin
          check("sb_write_order", wr_data, exp_q[idx][DATA_W-1:0]);
          exp_q.delete(idx);
        end
        regs[wr_addr] = wr_data;
        if (wr_addr == 10) w10_cnt++;
      end
    end
  end

  // ---------------- drivers ----------------
  task automatic align();
    @(posedge clk);
    #2;
  endtask

  task automatic send0(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    logic r;
    r = 0;
    req0_valid = 1; req0_addr = a; req0_data = d;
    for (int t = 0; t < 50; t++) begin
      @(negedge clk);
      r = req0_ready;
      @(posedge clk);
      if (r) break;
    end
    check("send0_accepted", r, 1);
    #2;
    req0_valid = 0;
  endtask

  task automatic send1(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    logic r;
    r = 0;
    req1_valid = 1; req1_addr = a; req1_data = d;
    for (int t = 0; t < 50; t++) begin
      @(negedge clk);
      r = req1_ready;
      @(posedge clk);
      if (r) break;
    end
    check("send1_accepted", r, 1);
    #2;
    req1_valid = 0;
  endtask

  // ---------------- directed sequence ----------------
  initial begin : main
    for (int i = 0; i < 32; i++) regs[i] = '0;
    req0_valid = 0; req0_addr = '0; req0_data = '0;
    req1_valid = 0; req1_addr = '0; req1_data = '0;
    chk_addr1 = 5'd0; chk_addr2 = 5'd0;
    repeat (2) @(posedge clk);
    #2 reset = 1;

    // Reset state
    @(negedge clk);
    check("rst_wr_en", wr_en, 0);
    check("rst_wr_addr", wr_addr, 0);
    check("rst_wr_data", wr_data, 0);
    check("rst_conflict_cnt", conflict_cnt, 0);
    check("rst_req0_ready", req0_ready, 1);
    check("rst_req1_ready", req1_ready, 1);

    // Single write: two-edge latency, one-cycle pulse
    align();
    send0(5'd3, 64'hAA);
    @(negedge clk);
    check("t1_wr_en_early", wr_en, 0);
    @(negedge clk);
    check("t1_wr_en", wr_en, 1);
    check("t1_wr_addr", wr_addr, 3);
    check("t1_wr_data", wr_data, 64'hAA);
    @(negedge clk);
    check("t1_wr_en_off", wr_en, 0);

    // XZR drop
    align();
    chk_addr1 = 5'd31;
    send1(5'd31, 64'hFF);
    repeat (4) begin
      @(negedge clk);
      check("t2_xzr_wr_en", wr_en, 0);
      check("t2_xzr_busy1", busy1, 0);
      check("t2_xzr_wr_addr_held", wr_addr, 3);
    end

    // Round-robin, two rounds
    align();
    chk_addr1 = 5'd4; chk_addr2 = 5'd5;
    fork send0(5'd4, 64'h40); send1(5'd5, 64'h50); join
    @(negedge clk);
    check("t3a_busy1", busy1, 1);
    @(negedge clk);
    check("t3a_first_addr", wr_addr, 4);
    check("t3a_first_data", wr_data, 64'h40);
    check("t3a_conflict", conflict_cnt, 1);
    @(negedge clk);
    check("t3a_second_addr", wr_addr, 5);
    align();
    fork send0(5'd4, 64'h41); send1(5'd5, 64'h51); join
    @(negedge clk);
    @(negedge clk);
    check("t3b_first_addr", wr_addr, 5);
    check("t3b_first_data", wr_data, 64'h51);
    check("t3b_conflict", conflict_cnt, 2);
    @(negedge clk);
    check("t3b_second_addr", wr_addr, 4);

    // Same-address, load one cycle earlier
    align();
    fork
      send1(5'd7, 64'd1);
      begin @(posedge clk); #2; send0(5'd7, 64'd2); end
    join
    @(negedge clk);
    check("t4a_first_addr", wr_addr, 7);
    check("t4a_first_data", wr_data, 1);
    @(negedge clk);
    check("t4a_second_data", wr_data, 2);

    // Same-address, simultaneous: load wins even though rr_ptr favours req0
    align();
    fork send0(5'd12, 64'h22); send1(5'd12, 64'h11); join
    @(negedge clk);
    check("t4b_idle", wr_en, 0);
    @(negedge clk);
    check("t4b_first_data", wr_data, 64'h11);
    check("t4b_conflict", conflict_cnt, 3);
    @(negedge clk);
    check("t4b_second_data", wr_data, 64'h22);

    // Back-pressure: both requesters streaming
    align();
    chk_addr1 = 5'd10; chk_addr2 = 5'd11;
    bp_phase = 1;
    fork
      for (int i = 0; i < 10; i++) send0(5'd10, 64'h100 + 64'(i));
      for (int i = 0; i < 10; i++) send1(5'd11, 64'h200 + 64'(i));
    join
    repeat (6) @(negedge clk);
    bp_phase = 0;
    check("t5_ready0_dropped", saw_low0, 1);
    check("t5_writes_to_r10", w10_cnt, 10);
    check("t5_r10_last", regs[10], 64'h109);
    check("t5_r11_last", regs[11], 64'h209);

    // Hazard then reset mid-pending
    align();
    chk_addr1 = 5'd0; chk_addr2 = 5'd9;
    send0(5'd9, 64'h99);
    #1;
    check("t6_busy2_pending", busy2, 1);
    reset = 0;
    #1;
    check("t6_rst_busy2", busy2, 0);
    check("t6_rst_wr_en", wr_en, 0);
    check("t6_rst_conflict", conflict_cnt, 0);
    repeat (2) @(posedge clk);
    #2 reset = 1;
    repeat (4) begin
      @(negedge clk);
      check("t6_no_stale_wr", wr_en, 0);
      check("t6_no_stale_busy2", busy2, 0);
    end

    // Final register image
    check("end_r3", regs[3], 64'hAA);
    check("end_r7", regs[7], 64'd2);
    check("end_r12", regs[12], 64'h22);
    check("end_r9_never", regs[9], 64'd0);
    check("end_r31_never", regs[31], 64'd0);
    check("end_queue_empty", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Global watchdog
  initial begin
    #20000;
    $display("FAIL watchdog: got timeout expected finish");
    errors++;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "watchdog");
  end

endmodule
